// File: rtl/dmem_store_buffer_if.sv
// Bundle of core-side store/load signals and dmem-port signals for one store buffer.
// The core/memory side uses master; the buffer uses slave.
interface dmem_store_buffer_if;
    logic        StoreValid;
    logic [31:0] StoreAddr;
    logic [31:0] StoreData;
    logic        StoreReady;
    logic        LoadValid;
    logic [31:0] LoadAddr;
    logic [31:0] LoadData;
    logic        LoadHit;
    logic        LoadStall;
    logic        Empty;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEnable;
    logic [31:0] MemReadData;

    modport master (
        output StoreValid, StoreAddr, StoreData, LoadValid, LoadAddr, MemReadData,
        input  StoreReady, LoadData, LoadHit, LoadStall, Empty,
               MemAddress, MemWriteData, MemWriteEnable
    );

    modport slave (
        input  StoreValid, StoreAddr, StoreData, LoadValid, LoadAddr, MemReadData,
        output StoreReady, LoadData, LoadHit, LoadStall, Empty,
               MemAddress, MemWriteData, MemWriteEnable
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// In-order store buffer in front of one dmem port: drains when the core is not loading,
// forwards the youngest pending store to loads, and forces a drain after STARVE blocked cycles.
module dmem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned STARVE = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    dmem_store_buffer_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE + 1);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic [29:0] ent_addr [DEPTH];
    logic [31:0] ent_data [DEPTH];

    logic enq;
    logic drain;
    logic forced;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.StoreAddr[1:0], bus.LoadAddr[1:0]};

    assign bus.StoreReady = (count != CW'(DEPTH));
    assign bus.Empty      = (count == '0);

    assign enq    = bus.StoreValid && bus.StoreReady;
    assign drain  = (count != '0) && (!bus.LoadValid || (starve == SW'(STARVE)));
    assign forced = drain && bus.LoadValid;

    // Memory port mux and oldest-to-youngest forwarding scan; later matches win.
    always_comb begin
        logic [PW-1:0] idx;
        idx                = head;
        bus.MemAddress     = bus.LoadAddr;
        bus.MemWriteData   = '0;
        bus.MemWriteEnable = 1'b0;
        bus.LoadStall      = forced;
        bus.LoadData       = bus.MemReadData;
        bus.LoadHit        = 1'b0;

        if (drain) begin
            bus.MemAddress     = {ent_addr[head], 2'b00};
            bus.MemWriteData   = ent_data[head];
            bus.MemWriteEnable = 1'b1;
        end

        if (bus.LoadValid && !forced) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if ((CW'(i) < count) && (ent_addr[idx] == bus.LoadAddr[31:2])) begin
                    bus.LoadHit  = 1'b1;
                    bus.LoadData = ent_data[idx];
                end
            end
        end
    end

    // Pointers, occupancy and starvation counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drain || (count == '0)) begin
                starve <= '0;
            end else if (bus.LoadValid && (starve != SW'(STARVE))) begin
                starve <= starve + SW'(1);
            end
        end
    end

    // Entry payloads carry no reset; validity comes from head/count.
    always_ff @(posedge CLK) begin
        if (enq) begin
            ent_addr[tail] <= bus.StoreAddr[31:2];
            ent_data[tail] <= bus.StoreData;
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a small word-addressed memory model on the port.
`timescale 1ns/1ps
module tb_dmem_store_buffer;
    logic CLK;
    logic RST;
    int   checks;
    int   failures;

    logic [31:0] mem [256];

    dmem_store_buffer_if bus();

    dmem_store_buffer #(.DEPTH(4), .STARVE(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign bus.MemReadData = mem[bus.MemAddress[9:2]];

    always @(posedge CLK) begin
        if (bus.MemWriteEnable) mem[bus.MemAddress[9:2]] <= bus.MemWriteData;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.StoreValid = 1'b1;
        bus.StoreAddr  = a;
        bus.StoreData  = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
        RST            = 1'b1;
        bus.StoreValid = 1'b0;
        bus.StoreAddr  = '0;
        bus.StoreData  = '0;
        bus.LoadValid  = 1'b0;
        bus.LoadAddr   = '0;

        // Reset values
        #2;
        check("rst_ready", 32'(bus.StoreReady), 1);
        check("rst_empty", 32'(bus.Empty), 1);
        check("rst_we", 32'(bus.MemWriteEnable), 0);
        check("rst_stall", 32'(bus.LoadStall), 0);
        check("rst_hit", 32'(bus.LoadHit), 0);
        cyc();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("idle_ready", 32'(bus.StoreReady), 1);
            check("idle_empty", 32'(bus.Empty), 1);
            check("idle_we", 32'(bus.MemWriteEnable), 0);
        end

        // Single store drains the following cycle
        store(32'h10, 32'hAAAA0001);
        #1;
        check("st1_no_we_same_cycle", 32'(bus.MemWriteEnable), 0);
        cyc();
        bus.StoreValid = 1'b0;
        #1;
        check("st1_we", 32'(bus.MemWriteEnable), 1);
        check("st1_addr", bus.MemAddress, 32'h10);
        check("st1_data", bus.MemWriteData, 32'hAAAA0001);
        check("st1_not_empty", 32'(bus.Empty), 0);
        cyc();
        check("st1_empty_after", 32'(bus.Empty), 1);
        check("st1_we_after", 32'(bus.MemWriteEnable), 0);
        check("st1_mem", mem[4], 32'hAAAA0001);

        // Forwarding picks the youngest of two same-address stores
        bus.LoadValid = 1'b1;
        bus.LoadAddr  = 32'h100;
        store(32'h20, 32'h1);
        cyc();
        store(32'h20, 32'h2);
        cyc();
        bus.StoreValid = 1'b0;
        bus.LoadAddr   = 32'h23;
        #1;
        check("fwd_hit", 32'(bus.LoadHit), 1);
        check("fwd_data", bus.LoadData, 32'h2);
        check("fwd_no_we", 32'(bus.MemWriteEnable), 0);
        cyc();
        bus.LoadAddr = 32'h24;
        #1;
        check("miss_hit", 32'(bus.LoadHit), 0);
        check("miss_data", bus.LoadData, 32'hDEAD0009);
        cyc();
        bus.LoadValid = 1'b0;
        #1;
        check("fwd_drain0_addr", bus.MemAddress, 32'h20);
        check("fwd_drain0_data", bus.MemWriteData, 32'h1);
        cyc();
        check("fwd_drain1_data", bus.MemWriteData, 32'h2);
        cyc();
        check("fwd_empty", 32'(bus.Empty), 1);
        check("fwd_mem", mem[8], 32'h2);

        // Fill to DEPTH while loading, refuse the 5th store until a drain frees a slot
        bus.LoadValid = 1'b1;
        bus.LoadAddr  = 32'h200;
        for (int i = 0; i < 4; i++) begin
            store(32'h40 + 32'(4 * i), 32'h101 + 32'(i));
            cyc();
        end
        store(32'h50, 32'h105);
        bus.LoadAddr = 32'h44;
        #1;
        check("full_ready", 32'(bus.StoreReady), 0);
        check("full_we", 32'(bus.MemWriteEnable), 0);
        check("full_fwd_data", bus.LoadData, 32'h102);
        cyc();
        check("full_ready_hold", 32'(bus.StoreReady), 0);
        bus.LoadValid = 1'b0;
        #1;
        check("full_drain_we", 32'(bus.MemWriteEnable), 1);
        check("full_drain_addr", bus.MemAddress, 32'h40);
        check("full_drain_refuse", 32'(bus.StoreReady), 0);
        cyc();
        check("st5_ready", 32'(bus.StoreReady), 1);
        check("st5_drain_addr", bus.MemAddress, 32'h44);
        cyc();
        bus.StoreValid = 1'b0;
        #1;
        check("order_addr2", bus.MemAddress, 32'h48);
        cyc();
        check("order_addr3", bus.MemAddress, 32'h4C);
        cyc();
        check("order_addr4", bus.MemAddress, 32'h50);
        check("order_data4", bus.MemWriteData, 32'h105);
        cyc();
        check("fill_empty", 32'(bus.Empty), 1);
        check("fill_mem", mem[19], 32'h104);

        // Starvation: forced drain after 8 blocked cycles, then the counter restarts
        bus.LoadValid = 1'b1;
        bus.LoadAddr  = 32'h64;
        store(32'h60, 32'h600);
        cyc();
        store(32'h64, 32'h640);
        #1;
        check("same_cycle_invisible", 32'(bus.LoadHit), 0);
        cyc();
        bus.StoreValid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("blk1_we", 32'(bus.MemWriteEnable), 0);
            check("blk1_hit", bus.LoadData, 32'h640);
            cyc();
        end
        #1;
        check("force1_we", 32'(bus.MemWriteEnable), 1);
        check("force1_stall", 32'(bus.LoadStall), 1);
        check("force1_addr", bus.MemAddress, 32'h60);
        check("force1_nohit", 32'(bus.LoadHit), 0);
        check("force1_data", bus.LoadData, 32'hDEAD0018);
        cyc();
        for (int k = 0; k < 8; k++) begin
            check("blk2_we", 32'(bus.MemWriteEnable), 0);
            check("blk2_stall", 32'(bus.LoadStall), 0);
            cyc();
        end
        check("force2_we", 32'(bus.MemWriteEnable), 1);
        check("force2_addr", bus.MemAddress, 32'h64);
        check("force2_data", bus.LoadData, 32'hDEAD0019);
        cyc();
        check("starve_empty", 32'(bus.Empty), 1);
        check("starve_mem_read", bus.LoadData, 32'h640);

        // Asynchronous reset discards pending stores
        bus.LoadAddr = 32'h80;
        store(32'h70, 32'h700);
        cyc();
        store(32'h74, 32'h740);
        cyc();
        store(32'h78, 32'h780);
        cyc();
        bus.StoreValid = 1'b0;
        #1;
        check("pre_rst_empty", 32'(bus.Empty), 0);
        #1;
        RST = 1'b1;
        #1;
        check("async_rst_empty", 32'(bus.Empty), 1);
        check("async_rst_we", 32'(bus.MemWriteEnable), 0);
        cyc();
        RST = 1'b0;
        bus.LoadValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("post_rst_we", 32'(bus.MemWriteEnable), 0);
        end
        check("post_rst_mem0", mem[28], 32'hDEAD001C);
        check("post_rst_mem1", mem[29], 32'hDEAD001D);
        check("post_rst_mem2", mem[30], 32'hDEAD001E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Per-core store buffer between one core's MEM stage and one port (A or B) of the dual-port word-addressed data memory.
- Accepts stores from the core without stalling, queues them in order, and drains them to the memory port in cycles when the core is not loading.
- Loads that hit a pending store get the youngest buffered data (store-to-load forwarding).
- A bounded-starvation rule keeps continuous loads from blocking drains forever.

Parameters:
DEPTH, 4, number of buffered stores; power of two, at least 2
STARVE, 8, consecutive blocked-drain cycles before a forced drain; at least 1

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-high reset
StoreValid  input  1  core presents a store this cycle
StoreAddr  input  32  store byte address; bits [1:0] ignored
StoreData  input  32  store word
StoreReady  output  1  buffer can accept a store this cycle
LoadValid  input  1  core presents a load this cycle
LoadAddr  input  32  load byte address; bits [1:0] ignored
LoadData  output  32  load result, combinational
LoadHit  output  1  LoadData came from the buffer
LoadStall  output  1  load not serviced this cycle; core must hold it
Empty  output  1  no pending stores; used as the fence/sync condition
MemAddress  output  32  to dmem AddressA/B
MemWriteData  output  32  to dmem WriteDataA/B
MemWriteEnable  output  1  to dmem WriteEnableA/B
MemReadData  input  32  from dmem ReadDataA/B, combinational read

Behaviour:
- State:
  - Circular array of DEPTH entries {word address [31:2], data}.
  - Head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, 0..DEPTH, of log2(DEPTH)+1 bits.
  - starve counter, 0..STARVE.
- Reset (asynchronous, RST=1): head, tail, count and starve are cleared. Entry contents are not cleared. Outputs during and after reset: StoreReady=1, Empty=1, MemWriteEnable=0, LoadStall=0, LoadHit=0.
- StoreReady = (count != DEPTH). It depends on registered state only; there is no combinational path from the drain decision. When the buffer is full and draining, a store is still refused that cycle.
- Enqueue: StoreValid && StoreReady. At the clock edge the entry is written at tail and tail advances. If StoreValid=1 while StoreReady=0, the store is dropped; the core must hold StoreValid until StoreReady=1.
- Drain mode (D), decided combinationally each cycle:
  - Normal: D = (count>0) && !LoadValid.
  - Forced: D = (count>0) && LoadValid && (starve==STARVE).
- In a drain cycle:
  - MemAddress = {head addr, 2'b00}, MemWriteData = head data, MemWriteEnable=1.
  - Head advances at the edge.
  - In a forced drain, LoadStall=1.
- When not draining: MemAddress = LoadAddr, MemWriteData = 0, MemWriteEnable = 0.
- Starve counter:
  - Increments (saturating at STARVE) in each cycle with count>0, LoadValid=1 and no drain.
  - Clears on any drain or when count==0.
- Count update:
  - +1 on enqueue only.
  - −1 on drain only.
  - Unchanged on simultaneous enqueue and drain.
- Load forwarding (LoadValid && !LoadStall):
  - LoadAddr[31:2] is compared against all valid entries.
  - The youngest match (closest to tail) supplies LoadData, with LoadHit=1.
  - Otherwise LoadData = MemReadData and LoadHit=0.
  - If LoadValid=0 or LoadStall=1: LoadData = MemReadData, LoadHit=0.
- Same-cycle ordering:
  - A store enqueued in cycle N is not visible to a load in cycle N. It is visible from cycle N+1.
  - The core's MEM stage orders a same-address store and load accordingly.
- Latency: a store enqueued in cycle N reaches memory no earlier than the edge ending cycle N+1.
- Drain is strictly FIFO. The memory sees the same store order as the core.
- Empty = (count==0). It depends on registered state only.
- Reset mid-operation: all pending stores are discarded and are never written to memory.

Test Plan:
- Reset, then no traffic -> StoreReady=1, Empty=1, MemWriteEnable=0 every cycle.
- Store 0x10←0xAAAA0001 with LoadValid=0 -> next cycle MemWriteEnable=1, MemAddress=0x10, MemWriteData=0xAAAA0001; then Empty=1.
- With LoadValid=1 held, store 0x20←0x1, then 0x20←0x2, then load 0x23 -> LoadHit=1, LoadData=0x2. A load of 0x24 -> LoadHit=0, LoadData=MemReadData.
- Four stores back-to-back with LoadValid=1 -> StoreReady=0 after the 4th. The 5th store is refused until a drain occurs.
- Pending store with LoadValid=1 held continuously, STARVE=8 -> after 8 blocked cycles, one cycle with MemWriteEnable=1 and LoadStall=1; the starve counter then restarts.
- Assert RST asynchronously with 3 entries pending -> Empty=1 immediately. No further MemWriteEnable pulses; the memory contents at those addresses are unchanged.
